// File: rtl/approx_mon_pkg.sv
// Shared definitions for the approximate-multiplier error monitor.
//   state_t   : run-control states (IDLE, RUN, DRAIN, DONE)
//   ED_W      : width of one error distance (fits |16-bit - 16-bit|)
//   sat_add   : accumulator + error distance, clamped to a w-bit maximum
//   sat_ovf   : 1 when that clamp applies
package approx_mon_pkg;

    localparam int ED_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Both helpers work on a 64-bit carrier so one definition serves any
    // accumulator width up to 64; callers truncate the result back.
    function automatic logic sat_ovf(input logic [63:0] acc,
                                     input logic [ED_W-1:0] ed,
                                     input int w);
        logic [64:0] s;
        s = {1'b0, acc} + 65'(ed);
        return (s >> w) != 65'd0;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [ED_W-1:0] ed,
                                            input int w);
        logic [64:0] s;
        s = {1'b0, acc} + 65'(ed);
        if ((s >> w) != 65'd0)
            return (64'd1 << w) - 64'd1;
        return s[63:0];
    endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample stream from the multiplier under test into the monitor.
//   in_valid : A, B, R_approx valid
//   in_ready : monitor accepts a sample this cycle
//   A, B     : 8-bit operands
//   R_approx : 16-bit approximate product
interface approx_err_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] R_approx;

    modport master (output in_valid, A, B, R_approx, input in_ready);
    modport slave  (input in_valid, A, B, R_approx, output in_ready);
endinterface

// File: rtl/approx_ed_stage.sv
// Two-stage error-distance datapath.
//   acc      : sample accepted this edge (captures operands into stage 1)
//   a, b     : operands, r_approx : approximate product
//   ed_vld   : stage-1 register holds a sample; ed is valid this cycle
//   ed       : |a*b - r_approx| of the stage-1 sample
// Stage 2 is the accumulation in the parent, so ed is combinational here.
module approx_ed_stage
    import approx_mon_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            acc,
    input  logic [7:0]      a,
    input  logic [7:0]      b,
    input  logic [15:0]     r_approx,
    output logic            ed_vld,
    output logic [ED_W-1:0] ed
);

    logic        v1;
    logic [15:0] exact_q;
    logic [15:0] r_q;
    logic [16:0] diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            exact_q <= '0;
            r_q     <= '0;
        end else begin
            v1 <= acc;
            if (acc) begin
                exact_q <= 16'(a) * 16'(b);
                r_q     <= r_approx;
            end
        end
    end

    // 17-bit signed difference; a negative result is negated on its low
    // 16 bits, which is exact because the magnitude never exceeds 65535.
    always_comb begin
        diff = {1'b0, exact_q} - {1'b0, r_q};
        ed   = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
    end

    assign ed_vld = v1;

endmodule

// File: rtl/approx_err_monitor.sv
// Error-metric monitor for 8x8 approximate multipliers.
//   clk, rst         : clock, synchronous active-high reset
//   start, n_samples : begin a run of n_samples (honoured in IDLE/DONE)
//   smp              : sample stream (slave side, in_ready driven here)
//   busy, done       : run in progress / results final
//   sample_cnt, err_cnt, sum_ed, max_ed, sum_sat : run statistics
module approx_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    approx_err_monitor_if.slave  smp,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [SUM_W-1:0]     sum_ed,
    output logic [ED_W-1:0]      max_ed,
    output logic                 sum_sat
);

    state_t            state;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  acc_cnt;
    logic              rdy_q;
    logic              accept;
    logic              ed_vld;
    logic [ED_W-1:0]   ed;
    logic [SUM_W-1:0]  sum_nxt;
    logic              ovf;

    assign smp.in_ready = rdy_q;
    assign accept       = smp.in_valid && rdy_q;

    approx_ed_stage u_ed (
        .clk      (clk),
        .rst      (rst),
        .acc      (accept),
        .a        (smp.A),
        .b        (smp.B),
        .r_approx (smp.R_approx),
        .ed_vld   (ed_vld),
        .ed       (ed)
    );

    always_comb begin
        sum_nxt = SUM_W'(sat_add(64'(sum_ed), ed, SUM_W));
        ovf     = sat_ovf(64'(sum_ed), ed, SUM_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_lat      <= '0;
            acc_cnt    <= '0;
            rdy_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            sum_sat    <= 1'b0;
        end else begin
            // Accumulate first; a start below overrides with the clear,
            // which is safe because the pipe is empty in IDLE/DONE.
            if (ed_vld) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                if (ed != '0)
                    err_cnt <= err_cnt + CNT_W'(1);
                if (ed > max_ed)
                    max_ed <= ed;
                sum_ed <= sum_nxt;
                if (ovf)
                    sum_sat <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        sum_ed     <= '0;
                        max_ed     <= '0;
                        sum_sat    <= 1'b0;
                        acc_cnt    <= '0;
                        if (n_samples != '0) begin
                            n_lat <= n_samples;
                            state <= RUN;
                            rdy_q <= 1'b1;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == n_lat) begin
                            state <= DRAIN;
                            rdy_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The last sample is accumulated on the edge where
                    // ed_vld is high; finish on the edge after that.
                    if (!ed_vld) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Sequential error-metric stage placed directly downstream of the 8x8 approximate multipliers. It consumes each operand pair and the approximate product, computes the exact product and the error distance internally, and accumulates per-run statistics: sample count, erroneous-sample count, sum of error distance, and maximum error distance. Host logic derives MED, ER and worst-case error from these outputs for hardware-in-the-loop characterisation of multiplier configurations.

## Interface
Parameters:
- CNT_W, 16: width of the sample-count request and the counters.
- SUM_W, 32: width of the error-distance accumulator. Must be ≥ 16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run. Only honoured in IDLE or DONE.
- n_samples  in  CNT_W  number of samples in the run. Latched on an accepted start.
- in_valid  in  1  A, B and R_approx are valid.
- in_ready  out  1  stage accepts a sample this cycle.
- A  in  8  multiplicand.
- B  in  8  multiplier.
- R_approx  in  16  approximate product from the multiplier under test.
- busy  out  1  run in progress, including pipeline drain.
- done  out  1  results final. Held high until the next accepted start, or reset.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with nonzero error distance.
- sum_ed  out  SUM_W  saturating sum of error distances.
- max_ed  out  16  largest error distance seen.
- sum_sat  out  1  sticky flag: sum_ed has saturated.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- Reset clears every output to 0.
- IDLE or DONE, with start=1:
  - If n_samples != 0: clear all results, latch n_samples, go to RUN.
  - If n_samples = 0: clear all results, go to DONE.
- RUN:
  - in_ready = 1 while accepted < n_samples.
  - A sample is accepted on an edge where in_valid && in_ready.
  - When the last sample is accepted, go to DRAIN.
  - start is ignored in RUN.
- DRAIN waits until the pipeline is empty, then goes to DONE.
- busy = 1 in RUN and DRAIN. done = 1 in DONE.
- in_ready = 0 in every state other than RUN.
- Stage 1, on accept: register exact = A*B (16-bit, unsigned), register R_approx, set v1.
- Stage 2, when v1 is set:
  - ed = |exact − R_approx|, computed as a 17-bit signed difference, magnitude truncated to 16 bits (the maximum value is 65535, so it always fits).
  - sample_cnt += 1.
  - err_cnt += (ed != 0).
  - max_ed = max(max_ed, ed).
  - sum_ed = sum_ed + ed, clamped to 2^SUM_W−1. Set sum_sat when the clamp applies; sum_sat stays set until the next start.
- Counters never wrap, because n_samples ≤ 2^CNT_W−1.
- rst during any state aborts the run, flushes the pipeline and clears all results in the same edge.

## Timing
- Throughput: one sample per cycle while in_valid stays high. in_valid gaps are allowed; the stage simply waits.
- Latency from accept to accumulated outputs is 2 edges: the sample is captured at edge k, and the outputs update at edge k+1.
- done rises at edge k+2, where k is the edge that accepted the last sample.
- For n_samples = 0, done rises at the edge following the start edge.
- Outputs are registered. Intermediate values are visible while busy, but are only final when done = 1.
- start in DONE clears the results and drops done at the same edge. in_ready rises in the next cycle.

## Structure
- Shared package approx_mon_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the ED_W = 16 constant;
  - the saturating-add function.
- One sub-module, approx_ed_stage: the two-stage datapath (exact multiply, absolute difference, valid pipe).
- The FSM, counters and accumulators live in the top module.

## Test plan
- **Reset values.** Hold rst for 3 cycles → all outputs 0, in_ready = 0, state IDLE.
- **Basic run.** start with n_samples = 4, then feed these samples (exact product, error distance):
  - (255,255,R=65024): exact 65025, ed 1.
  - (15,15,R=240): exact 225, ed 15.
  - (0,7,R=0): exact 0, ed 0.
  - (100,3,R=296): exact 300, ed 4.
  - Required: sample_cnt = 4, err_cnt = 3, sum_ed = 20, max_ed = 15, sum_sat = 0, and done 2 edges after the 4th accept.
- **Backpressure and extra samples.** Same 4 samples with in_valid low for 3 cycles between samples 2 and 3, plus a 5th valid sample → identical results. The 5th sample is not accepted (in_ready = 0).
- **Zero-length run.** start with n_samples = 0 → done = 1 the next cycle, all counts 0, in_ready never asserted.
- **Saturation.** SUM_W = 16, n_samples = 2, samples (255,255,R=0) twice → sum_ed = 65535, sum_sat = 1, max_ed = 65025.
- **Reset and start interaction.** Assert rst after 2 of 4 samples → all outputs 0 next cycle. A new run then gives fresh results. start asserted during RUN is ignored, and n_samples is unchanged.
